// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub FSM states
// and opcode encodings for the serial datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; the only arithmetic
// cell in the serial add/sub path.
module full_adder_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // Plain sum and majority carry
  always_comb begin
    o_sum  = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
  end

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial add/subtract: one adder pass per clock,
// LSB first, with carry/overflow flags and done pulse.
module bit_serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovfl
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  addsub_state_t    r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_part;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovfl;

  logic w_sum;
  logic w_cout;
  logic w_accept;
  logic w_last;

  full_adder_1bit u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Start is honoured in IDLE and DONE only
  always_comb begin
    w_accept = start && (r_state != RUN);
    w_last   = (r_cnt == LAST);
  end

  // State sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    r_state <= w_accept ? RUN : IDLE;
        RUN:     r_state <= w_last ? DONE : RUN;
        DONE:    r_state <= w_accept ? RUN : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand shifters, carry flop, bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= (sub == OP_SUB) ? ~b : b;
      r_part  <= '0;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_part  <= (WIDTH-1)'({w_sum, r_part} >> 1);
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result and flags latch on the MSB pass only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovfl   <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_result <= {w_sum, r_part};
      r_cout   <= w_cout;
      r_ovfl   <= r_carry ^ w_cout;
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovfl   = r_ovfl;

endmodule

// File: doc/bit_serial_addsub.md
# bit_serial_addsub

Multi-cycle add/subtract unit that reuses a single `full_adder_1bit` instance serially, one bit per clock, LSB first. It sits beside the ALU as a low-area arithmetic path. It accepts a start request with two WIDTH-bit operands, sequences WIDTH adder passes through an internal carry flop, and returns a registered result with carry-out and signed-overflow flags, signalled by a one-cycle done pulse.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 2..64
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when busy=0
- sub  input  1  0 = A+B, 1 = A−B; latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result/flags update
- result  output  WIDTH  registered sum/difference; held until the next completion
- cout  output  1  final carry-out; for subtract, 1 = no borrow
- ovfl  output  1  two's-complement overflow of the operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Load shift registers A←a and B←(sub ? ~b : b).
  - Set carry←sub and bit counter←0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, each edge:
  - Adder inputs are A[0], B[0] and the carry flop.
  - Shift the sum bit into the MSB of the partial-result register; shift A and B right.
  - carry←adder Cout; counter increments.
- RUN with counter==WIDTH−1 (the MSB pass):
  - result←{sum, partial[WIDTH−1:1]}.
  - cout←adder Cout.
  - ovfl←carry flop (carry into MSB) XOR adder Cout.
  - Go to DONE.
- result, cout and ovfl are written only on the RUN→DONE edge and are stable otherwise.
- start while busy=1 is ignored and not queued. Operands may change freely after the start edge.
- Arithmetic is modulo 2^WIDTH. Counter width is $clog2(WIDTH).
- Reset, asynchronous and including mid-operation:
  - State→IDLE, and busy, done, result, cout, ovfl, carry, counter and shift registers all →0.
  - An aborted operation never produces a done pulse.

## Timing
- Start sampled at edge E0: busy=1 from E0 through edge E0+WIDTH. Bit i is computed in the cycle after edge E0+i.
- At edge E0+WIDTH, result, cout and ovfl update and done=1 for exactly that one cycle (busy=0).
- Total latency from start edge to done: WIDTH+1 edges counted inclusive of E0, i.e. done is visible WIDTH cycles after start is sampled.
- Back-to-back: start=1 during the DONE cycle is accepted. The next operation begins without an IDLE cycle, giving a throughput of one result per WIDTH+1 cycles.
- busy and done are mutually exclusive. done is a registered state decode, not combinational from inputs.

## Structure
- Shared package `alu_pkg`:
  - `addsub_state_t` enum {IDLE, RUN, DONE}.
  - Opcode constants OP_ADD=1'b0 and OP_SUB=1'b1.
- Single sub-module: one instance of `full_adder_1bit`. The carry flop, counter, shift registers and FSM live in `bit_serial_addsub`.

## Test plan
- Reset with no start → busy=0, done=0, result=0, cout=0, ovfl=0. Assert rst mid-RUN (after bit 3) → IDLE immediately, no done pulse, result=0.
- WIDTH=8, add a=8'h7F, b=8'h01 → done WIDTH cycles after start with result=8'h80, cout=0, ovfl=1; busy high for exactly 8 cycles.
- WIDTH=8, add a=8'hFF, b=8'h01 → result=8'h00, cout=1, ovfl=0.
- WIDTH=8, subtract a=8'h05, b=8'h07 → result=8'hFE, cout=0, ovfl=0. Subtract a=8'h80, b=8'h01 → result=8'h7F, cout=1, ovfl=1.
- Pulse start again during RUN with different operands → ignored; the first result is unchanged. Assert start in the DONE cycle → second operation accepted, and its done arrives WIDTH+1 cycles after the first.
- Randomised WIDTH=16 sweep of 1000 operations → result, cout and ovfl match the reference model a±b; done count equals accepted-start count.
